equeue_int_param: RTL and testbench
===================================

Name: equeue_int_param

Overview:
- Parametrised, age-ordered, collapsing integer issue queue between the dispatch unit and the integer issue/execute unit.
- Holds up to DEPTH renamed instructions and captures operands broadcast on the CDB, including for the instruction being dispatched in the same cycle.
- Issues the oldest entry whose operands are both valid.
- Adds single-level branch speculation: each entry carries a speculative bit. A branch flush kills speculative entries; a branch commit clears the bit.

Parameters:
DEPTH, 4, number of queue entries (>=2)
OPC_W, 6, opcode width
TAG_W, 6, physical/rename tag width
DATA_W, 32, operand data width
CNT_W, $clog2(DEPTH+1), occupancy counter width

Ports:
clk  in  1  clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
dispatch_opcode  in  OPC_W  opcode of incoming instruction
dispatch_rdtag  in  TAG_W  destination tag
dispatch_rstag  in  TAG_W  rs source tag
dispatch_rttag  in  TAG_W  rt source tag
dispatch_rsdata  in  DATA_W  rs value, meaningful when rsvalid
dispatch_rtdata  in  DATA_W  rt value, meaningful when rtvalid
dispatch_rsvalid  in  1  rs already resolved
dispatch_rtvalid  in  1  rt already resolved
dispatch_spec  in  1  instruction is behind an unresolved branch
dispatch_en  in  1  dispatch request
dispatch_ready  out  1  queue can accept this cycle
cdb_tag  in  TAG_W  broadcast tag
cdb_data  in  DATA_W  broadcast data
cdb_valid  in  1  broadcast valid
branch_flush  in  1  mispredict: kill all speculative entries
branch_commit  in  1  branch correct: clear all speculative bits
issueint_opcode  out  OPC_W  selected entry opcode
issueint_rdtag  out  TAG_W  selected entry destination tag
issueint_rsdata  out  DATA_W  selected entry rs data
issueint_rtdata  out  DATA_W  selected entry rt data
issueint_ready  out  1  some valid entry has both operands valid
issueint_done  in  1  issue unit consumes the selected entry this cycle
occupancy  out  CNT_W  number of valid entries

Behaviour:
- Reset (async, reset_n=0): all entry fields and valid/spec bits cleared.
  - Outputs during and after reset: issueint_ready=0, occupancy=0, dispatch_ready=1, issueint_* data=0.
  - Reset asserted mid-operation discards all entries immediately; no issue or dispatch completes in that cycle.
- Ordering: entry 0 is oldest. New entries enter at the lowest free slot above existing ones; holes left by issued or flushed entries collapse downward each cycle. Relative age is always preserved.
- Select: combinational, from registered state. Lowest index i with valid & rsvalid & rtvalid. issueint_* show entry i; if none is selected, they show entry 0. issueint_ready = any selectable entry.
- Issue: an entry is removed at the clock edge when issueint_done=1 and issueint_ready=1. issueint_done with issueint_ready=0 is ignored.
- Dispatch accept: dispatch_en & dispatch_ready.
  - dispatch_ready = (occupancy < DEPTH) | (issueint_ready & issueint_done). It is combinational on issueint_done.
  - dispatch_en while not ready: instruction dropped, no state change.
- CDB capture, every cycle cdb_valid=1:
  - Any valid entry with a non-valid operand whose tag equals cdb_tag latches cdb_data and sets that operand's valid bit to 1.
  - Capture also applies to the dispatching instruction and to entries shifting in the same cycle.
  - The valid bit is always exactly 1'b1, never derived from data.
  - An entry issued in the same cycle is simply removed.
  - Captured operands can be selected in the next cycle, not the same cycle.
- Flush (branch_flush=1): every entry with spec=1 is invalidated at the edge, and so is a dispatching instruction with dispatch_spec=1. Non-speculative entries survive and collapse in age order. The same-cycle issue still removes the selected entry whether or not it is speculative; killing it downstream is the issue unit's responsibility.
- Commit (branch_commit=1): all spec bits, including the one on a dispatching instruction, are cleared at the edge.
- branch_flush and branch_commit together: flush wins.
- Simultaneous dispatch + issue + CDB + flush in one cycle must all apply in one edge with no lost or duplicated entry.
- occupancy next = occupancy + accepted − issued − flushed, where accepted counts only dispatches that are not themselves flushed. It never exceeds DEPTH.
- Latency: dispatch with both operands valid → issueint_ready at the next cycle (minimum 1 cycle).

Test Plan:
- Reset: hold reset_n=0 with random inputs → issueint_ready=0, occupancy=0, dispatch_ready=1. Assert reset_n=0 with 3 entries held → occupancy=0 immediately.
- Fill: 4 dispatches, rsvalid=0 tag 5, no CDB → occupancy=4, dispatch_ready=0. A 5th dispatch_en is dropped. Then issueint_done with none ready → no change.
- Out of order: entry0 waits on rs tag 5, entry1 ready with rdtag 0x12 → issueint_rdtag=0x12 issues. Next, cdb_tag=5, cdb_data=0xDEADBEEF → one cycle later entry0 issues with rsdata=0xDEADBEEF.
- Full with issue: queue full, issueint_done=1 and dispatch_en=1 in the same cycle → dispatch_ready=1, occupancy stays 4, new entry is youngest.
- Dispatch bypass: dispatch rttag=9, rtvalid=0 while cdb_tag=9, cdb_data=0x00000042 → next cycle entry ready, issueint_rtdata=0x42.
- Speculation: entries A (spec=0), B (spec=1), C (spec=0), then branch_flush → occupancy=2, order A,C. Repeat, then branch_commit, then branch_flush → occupancy unchanged.

Source files
------------

// File: rtl/equeue_int_param.sv
// equeue_int_param
// Age-ordered, collapsing integer issue queue with single-level branch
// speculation. Slot 0 always holds the oldest instruction. Every cycle the
// surviving entries are packed downward in age order, and an accepted
// dispatch is appended behind them.
//
// Ports:
//   clk, reset_n             clock, asynchronous active-low reset
//   dispatch_*               incoming renamed instruction and handshake
//   cdb_tag/data/valid       common data bus broadcast
//   branch_flush             kill every speculative entry
//   branch_commit            clear every speculative bit
//   issueint_*               oldest ready entry (entry 0 when none is ready)
//   issueint_done            issue unit consumes the selected entry
//   occupancy                number of valid entries
module equeue_int_param #(
  parameter int DEPTH  = 4,
  parameter int OPC_W  = 6,
  parameter int TAG_W  = 6,
  parameter int DATA_W = 32,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [OPC_W-1:0]  dispatch_opcode,
  input  logic [TAG_W-1:0]  dispatch_rdtag,
  input  logic [TAG_W-1:0]  dispatch_rstag,
  input  logic [TAG_W-1:0]  dispatch_rttag,
  input  logic [DATA_W-1:0] dispatch_rsdata,
  input  logic [DATA_W-1:0] dispatch_rtdata,
  input  logic              dispatch_rsvalid,
  input  logic              dispatch_rtvalid,
  input  logic              dispatch_spec,
  input  logic              dispatch_en,
  output logic              dispatch_ready,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic              cdb_valid,
  input  logic              branch_flush,
  input  logic              branch_commit,
  output logic [OPC_W-1:0]  issueint_opcode,
  output logic [TAG_W-1:0]  issueint_rdtag,
  output logic [DATA_W-1:0] issueint_rsdata,
  output logic [DATA_W-1:0] issueint_rtdata,
  output logic              issueint_ready,
  input  logic              issueint_done,
  output logic [CNT_W-1:0]  occupancy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic              valid;
    logic              spec;
    logic [OPC_W-1:0]  opc;
    logic [TAG_W-1:0]  rd;
    logic [TAG_W-1:0]  rs_tag;
    logic [TAG_W-1:0]  rt_tag;
    logic              rs_v;
    logic              rt_v;
    logic [DATA_W-1:0] rs_d;
    logic [DATA_W-1:0] rt_d;
  } entry_t;

  // Snoop the CDB into one entry and apply a branch commit to its spec bit.
  // The operand valid bit is forced to 1 on a tag hit, independent of data.
  function automatic entry_t capture(input entry_t e, input logic cv,
                                     input logic [TAG_W-1:0] ct,
                                     input logic [DATA_W-1:0] cd,
                                     input logic commit);
    entry_t o;
    o = e;
    o.spec = e.spec & ~commit;
    if (cv && !e.rs_v && (e.rs_tag == ct)) begin
      o.rs_v = 1'b1;
      o.rs_d = cd;
    end
    if (cv && !e.rt_v && (e.rt_tag == ct)) begin
      o.rt_v = 1'b1;
      o.rt_d = cd;
    end
    return o;
  endfunction

  entry_t           r_q [DEPTH];
  logic [CNT_W-1:0] r_count;

  entry_t           w_cap [DEPTH];
  entry_t           w_q_next [DEPTH];
  entry_t           w_disp_raw;
  entry_t           w_disp;
  logic [CNT_W-1:0] w_count_next;
  logic [DEPTH-1:0] w_rdy_vec;
  logic [DEPTH-1:0] w_keep;
  logic [IDX_W-1:0] w_sel_idx;
  logic             w_issue;
  logic             w_disp_accept;
  logic             w_disp_keep;

  // Per-entry readiness, survival and CDB-updated contents.
  // An entry survives unless it is issued this edge or killed by a flush.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      assign w_rdy_vec[gi] = r_q[gi].valid & r_q[gi].rs_v & r_q[gi].rt_v;
      assign w_keep[gi]    = r_q[gi].valid
                           & ~(w_issue && (w_sel_idx == IDX_W'(gi)))
                           & ~(branch_flush & r_q[gi].spec);
      assign w_cap[gi]     = capture(r_q[gi], cdb_valid, cdb_tag, cdb_data,
                                     branch_commit);
    end
  endgenerate

  // Oldest ready entry wins: scanning from the top leaves the lowest index.
  always_comb begin
    w_sel_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (w_rdy_vec[i]) begin
        w_sel_idx = IDX_W'(i);
      end
    end
  end

  assign issueint_ready = |w_rdy_vec;
  assign w_issue        = issueint_ready & issueint_done;
  assign dispatch_ready = (r_count < CNT_W'(DEPTH)) | w_issue;
  assign w_disp_accept  = dispatch_en & dispatch_ready;
  assign w_disp_keep    = w_disp_accept & ~(branch_flush & dispatch_spec);

  always_comb begin
    w_disp_raw        = '0;
    w_disp_raw.valid  = 1'b1;
    w_disp_raw.spec   = dispatch_spec;
    w_disp_raw.opc    = dispatch_opcode;
    w_disp_raw.rd     = dispatch_rdtag;
    w_disp_raw.rs_tag = dispatch_rstag;
    w_disp_raw.rt_tag = dispatch_rttag;
    w_disp_raw.rs_v   = dispatch_rsvalid;
    w_disp_raw.rt_v   = dispatch_rtvalid;
    w_disp_raw.rs_d   = dispatch_rsdata;
    w_disp_raw.rt_d   = dispatch_rtdata;
    w_disp            = capture(w_disp_raw, cdb_valid, cdb_tag, cdb_data,
                                branch_commit);
  end

  // Collapse: survivors are packed in age order, then the new instruction.
  // A flush leaves only non-speculative survivors, so their spec bits need
  // no separate handling when flush and commit coincide.
  always_comb begin
    int pos;
    w_q_next = '{default: '0};
    pos = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_keep[i]) begin
        w_q_next[IDX_W'(pos)] = w_cap[i];
        pos = pos + 1;
      end
    end
    if (w_disp_keep && (pos < DEPTH)) begin
      w_q_next[IDX_W'(pos)] = w_disp;
      pos = pos + 1;
    end
    w_count_next = CNT_W'(pos);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_q[i] <= '0;
      end
      r_count <= '0;
    end else begin
      r_q     <= w_q_next;
      r_count <= w_count_next;
    end
  end

  assign issueint_opcode = r_q[w_sel_idx].opc;
  assign issueint_rdtag  = r_q[w_sel_idx].rd;
  assign issueint_rsdata = r_q[w_sel_idx].rs_d;
  assign issueint_rtdata = r_q[w_sel_idx].rt_d;
  assign occupancy       = r_count;

endmodule

// File: tb/tb_equeue_int_param.sv
// Self-checking bench for equeue_int_param: directed scenarios plus a
// randomized run checked against a queue-based reference model.
module tb_equeue_int_param;

  localparam int DEPTH  = 4;
  localparam int OPC_W  = 6;
  localparam int TAG_W  = 6;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 3;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [OPC_W-1:0]  dispatch_opcode;
  logic [TAG_W-1:0]  dispatch_rdtag;
  logic [TAG_W-1:0]  dispatch_rstag;
  logic [TAG_W-1:0]  dispatch_rttag;
  logic [DATA_W-1:0] dispatch_rsdata;
  logic [DATA_W-1:0] dispatch_rtdata;
  logic              dispatch_rsvalid;
  logic              dispatch_rtvalid;
  logic              dispatch_spec;
  logic              dispatch_en;
  logic              dispatch_ready;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic              cdb_valid;
  logic              branch_flush;
  logic              branch_commit;
  logic [OPC_W-1:0]  issueint_opcode;
  logic [TAG_W-1:0]  issueint_rdtag;
  logic [DATA_W-1:0] issueint_rsdata;
  logic [DATA_W-1:0] issueint_rtdata;
  logic              issueint_ready;
  logic              issueint_done;
  logic [CNT_W-1:0]  occupancy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  equeue_int_param #(
    .DEPTH(DEPTH), .OPC_W(OPC_W), .TAG_W(TAG_W), .DATA_W(DATA_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .dispatch_opcode(dispatch_opcode), .dispatch_rdtag(dispatch_rdtag),
    .dispatch_rstag(dispatch_rstag), .dispatch_rttag(dispatch_rttag),
    .dispatch_rsdata(dispatch_rsdata), .dispatch_rtdata(dispatch_rtdata),
    .dispatch_rsvalid(dispatch_rsvalid), .dispatch_rtvalid(dispatch_rtvalid),
    .dispatch_spec(dispatch_spec), .dispatch_en(dispatch_en),
    .dispatch_ready(dispatch_ready),
    .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_valid(cdb_valid),
    .branch_flush(branch_flush), .branch_commit(branch_commit),
    .issueint_opcode(issueint_opcode), .issueint_rdtag(issueint_rdtag),
    .issueint_rsdata(issueint_rsdata), .issueint_rtdata(issueint_rtdata),
    .issueint_ready(issueint_ready), .issueint_done(issueint_done),
    .occupancy(occupancy)
  );

  // Reference model: an age-ordered list of waiting instructions.
  typedef struct {
    logic [OPC_W-1:0]  opc;
    logic [TAG_W-1:0]  rd;
    logic [TAG_W-1:0]  rst;
    logic [TAG_W-1:0]  rtt;
    logic [DATA_W-1:0] rsd;
    logic [DATA_W-1:0] rtd;
    logic              rsv;
    logic              rtv;
    logic              spec;
  } ent_t;

  ent_t mq[$];

  function automatic int model_sel();
    for (int i = 0; i < mq.size(); i++) begin
      if (mq[i].rsv && mq[i].rtv) return i;
    end
    return -1;
  endfunction

  function automatic ent_t model_snoop(input ent_t e);
    ent_t o;
    o = e;
    if (cdb_valid && !o.rsv && o.rst == cdb_tag) begin
      o.rsv = 1'b1;
      o.rsd = cdb_data;
    end
    if (cdb_valid && !o.rtv && o.rtt == cdb_tag) begin
      o.rtv = 1'b1;
      o.rtd = cdb_data;
    end
    return o;
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    ent_t nq[$];
    ent_t e;
    int   s;
    bit   iss;
    if (!reset_n) begin
      mq.delete();
      return;
    end
    s   = model_sel();
    iss = issueint_done && (s >= 0);
    for (int i = 0; i < mq.size(); i++) begin
      if (iss && i == s) continue;
      if (branch_flush && mq[i].spec) continue;
      e = model_snoop(mq[i]);
      if (branch_commit) e.spec = 1'b0;
      nq.push_back(e);
    end
    if (dispatch_en && (mq.size() < DEPTH || iss) &&
        !(branch_flush && dispatch_spec)) begin
      e.opc  = dispatch_opcode;
      e.rd   = dispatch_rdtag;
      e.rst  = dispatch_rstag;
      e.rtt  = dispatch_rttag;
      e.rsd  = dispatch_rsdata;
      e.rtd  = dispatch_rtdata;
      e.rsv  = dispatch_rsvalid;
      e.rtv  = dispatch_rtvalid;
      e.spec = dispatch_spec && !branch_commit;
      e      = model_snoop(e);
      nq.push_back(e);
    end
    mq = nq;
  endtask

  task automatic idle();
    dispatch_opcode  = '0;
    dispatch_rdtag   = '0;
    dispatch_rstag   = '0;
    dispatch_rttag   = '0;
    dispatch_rsdata  = '0;
    dispatch_rtdata  = '0;
    dispatch_rsvalid = 1'b0;
    dispatch_rtvalid = 1'b0;
    dispatch_spec    = 1'b0;
    dispatch_en      = 1'b0;
    cdb_tag          = '0;
    cdb_data         = '0;
    cdb_valid        = 1'b0;
    branch_flush     = 1'b0;
    branch_commit    = 1'b0;
    issueint_done    = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    idle();
  endtask

  task automatic disp(input logic [OPC_W-1:0] opc, input logic [TAG_W-1:0] rd,
                      input logic [TAG_W-1:0] rst, input logic [TAG_W-1:0] rtt,
                      input logic [DATA_W-1:0] rsd, input logic [DATA_W-1:0] rtd,
                      input logic rsv, input logic rtv, input logic spec);
    dispatch_en      = 1'b1;
    dispatch_opcode  = opc;
    dispatch_rdtag   = rd;
    dispatch_rstag   = rst;
    dispatch_rttag   = rtt;
    dispatch_rsdata  = rsd;
    dispatch_rtdata  = rtd;
    dispatch_rsvalid = rsv;
    dispatch_rtvalid = rtv;
    dispatch_spec    = spec;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 4; c++) begin
      disp(6'($urandom), 6'($urandom), 6'($urandom), 6'($urandom), $urandom,
           $urandom, 1'b1, 1'b1, 1'($urandom));
      issueint_done = 1'b1;
      cdb_valid = 1'b1;
      @(negedge clk);
      n_tests++;
      if (issueint_ready !== 1'b0 || occupancy !== 3'd0 || dispatch_ready !== 1'b1 ||
          issueint_rsdata !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_hold: ready=%b occ=%0d dready=%b rsdata=%h required 0/0/1/0",
                 issueint_ready, occupancy, dispatch_ready, issueint_rsdata);
      end
      step();
    end
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      disp(6'd1, 6'(k), 6'd5, 6'd6, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
      step();
    end
    @(negedge clk);
    n_tests++;
    if (occupancy !== 3'd3) begin
      n_fail++;
      $display("FAIL reset_pre_occ: got %0d required 3", occupancy);
    end
    reset_n = 1'b0;
    #1;
    n_tests++;
    if (occupancy !== 3'd0 || issueint_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: occ=%0d ready=%b required 0/0", occupancy, issueint_ready);
    end
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_fill();
    for (int k = 0; k < 4; k++) begin
      disp(6'd2, 6'(8 + k), 6'd5, 6'd0, 32'd0, 32'd1, 1'b0, 1'b1, 1'b0);
      step();
    end
    @(negedge clk);
    n_tests++;
    if (occupancy !== 3'd4 || dispatch_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_full: occ=%0d dready=%b required 4/0", occupancy, dispatch_ready);
    end
    disp(6'd3, 6'h3F, 6'd1, 6'd1, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0);
    step();
    @(negedge clk);
    n_tests++;
    if (occupancy !== 3'd4 || issueint_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_drop: occ=%0d ready=%b required 4/0", occupancy, issueint_ready);
    end
    issueint_done = 1'b1;
    #1;
    n_tests++;
    if (dispatch_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_done_noready: dready=%b required 0", dispatch_ready);
    end
    step();
    @(negedge clk);
    n_tests++;
    if (occupancy !== 3'd4) begin
      n_fail++;
      $display("FAIL fill_done_ignored: occ=%0d required 4", occupancy);
    end
    do_reset();
  endtask

  task automatic test_out_of_order();
    disp(6'd4, 6'h11, 6'd5, 6'd0, 32'd0, 32'd2, 1'b0, 1'b1, 1'b0);
    step();
    disp(6'd5, 6'h12, 6'd1, 6'd2, 32'd10, 32'd20, 1'b1, 1'b1, 1'b0);
    step();
    @(negedge clk);
    n_tests++;
    if (issueint_ready !== 1'b1 || issueint_rdtag !== 6'h12 || issueint_rsdata !== 32'd10) begin
      n_fail++;
      $display("FAIL ooo_first: ready=%b rdtag=%h rsdata=%h required 1/12/a",
               issueint_ready, issueint_rdtag, issueint_rsdata);
    end
    issueint_done = 1'b1;
    step();
    cdb_valid = 1'b1;
    cdb_tag   = 6'd5;
    cdb_data  = 32'hDEADBEEF;
    @(negedge clk);
    n_tests++;
    if (issueint_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ooo_same_cycle: ready=%b required 0", issueint_ready);
    end
    step();
    @(negedge clk);
    n_tests++;
    if (issueint_ready !== 1'b1 || issueint_rdtag !== 6'h11 || issueint_rsdata !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL ooo_wake: ready=%b rdtag=%h rsdata=%h required 1/11/deadbeef",
               issueint_ready, issueint_rdtag, issueint_rsdata);
    end
    issueint_done = 1'b1;
    step();
    @(negedge clk);
    n_tests++;
    if (occupancy !== 3'd0) begin
      n_fail++;
      $display("FAIL ooo_empty: occ=%0d required 0", occupancy);
    end
    do_reset();
  endtask

  task automatic test_full_issue();
    logic [TAG_W-1:0] order [4];
    order[0] = 6'h30; order[1] = 6'h31; order[2] = 6'h32; order[3] = 6'h3F;
    for (int k = 0; k < 3; k++) begin
      disp(6'd6, 6'(6'h30 + k), 6'd5, 6'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
      step();
    end
    disp(6'd7, 6'h33, 6'd0, 6'd0, 32'd1, 32'd1, 1'b1, 1'b1, 1'b0);
    step();
    disp(6'd8, 6'h3F, 6'd5, 6'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    issueint_done = 1'b1;
    @(negedge clk);
    n_tests++;
    if (dispatch_ready !== 1'b1 || issueint_rdtag !== 6'h33) begin
      n_fail++;
      $display("FAIL full_issue_ready: dready=%b rdtag=%h required 1/33",
               dispatch_ready, issueint_rdtag);
    end
    step();
    @(negedge clk);
    n_tests++;
    if (occupancy !== 3'd4) begin
      n_fail++;
      $display("FAIL full_issue_occ: occ=%0d required 4", occupancy);
    end
    cdb_valid = 1'b1;
    cdb_tag   = 6'd5;
    cdb_data  = 32'h5555;
    step();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_tests++;
      if (issueint_ready !== 1'b1 || issueint_rdtag !== order[k]) begin
        n_fail++;
        $display("FAIL full_issue_order%0d: ready=%b rdtag=%h required 1/%h",
                 k, issueint_ready, issueint_rdtag, order[k]);
      end
      issueint_done = 1'b1;
      step();
    end
    do_reset();
  endtask

  task automatic test_bypass();
    disp(6'd9, 6'h21, 6'd0, 6'd9, 32'd3, 32'd0, 1'b1, 1'b0, 1'b0);
    cdb_valid = 1'b1;
    cdb_tag   = 6'd9;
    cdb_data  = 32'h00000042;
    step();
    @(negedge clk);
    n_tests++;
    if (issueint_ready !== 1'b1 || issueint_rtdata !== 32'h42 || issueint_rdtag !== 6'h21) begin
      n_fail++;
      $display("FAIL bypass: ready=%b rtdata=%h rdtag=%h required 1/42/21",
               issueint_ready, issueint_rtdata, issueint_rdtag);
    end
    issueint_done = 1'b1;
    step();
    do_reset();
  endtask

  task automatic test_spec();
    disp(6'd1, 6'h0A, 6'd5, 6'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0); step();
    disp(6'd1, 6'h0B, 6'd5, 6'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1); step();
    disp(6'd1, 6'h0C, 6'd5, 6'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0); step();
    branch_flush = 1'b1;
    step();
    @(negedge clk);
    n_tests++;
    if (occupancy !== 3'd2) begin
      n_fail++;
      $display("FAIL spec_flush_occ: occ=%0d required 2", occupancy);
    end
    cdb_valid = 1'b1;
    cdb_tag   = 6'd5;
    cdb_data  = 32'h77;
    step();
    @(negedge clk);
    n_tests++;
    if (issueint_rdtag !== 6'h0A || issueint_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL spec_order_a: rdtag=%h ready=%b required 0a/1", issueint_rdtag, issueint_ready);
    end
    issueint_done = 1'b1;
    step();
    @(negedge clk);
    n_tests++;
    if (issueint_rdtag !== 6'h0C || issueint_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL spec_order_c: rdtag=%h ready=%b required 0c/1", issueint_rdtag, issueint_ready);
    end
    issueint_done = 1'b1;
    step();
    disp(6'd1, 6'h0A, 6'd5, 6'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0); step();
    disp(6'd1, 6'h0B, 6'd5, 6'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1); step();
    disp(6'd1, 6'h0C, 6'd5, 6'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0); step();
    branch_commit = 1'b1;
    step();
    branch_flush = 1'b1;
    step();
    @(negedge clk);
    n_tests++;
    if (occupancy !== 3'd3) begin
      n_fail++;
      $display("FAIL spec_commit_occ: occ=%0d required 3", occupancy);
    end
    do_reset();
  endtask

  task automatic test_random();
    int s;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) != 0) begin
        disp(6'($urandom), 6'($urandom), 6'($urandom_range(0, 7)),
             6'($urandom_range(0, 7)), $urandom, $urandom,
             1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0),
             1'($urandom));
      end
      cdb_valid     = 1'($urandom);
      cdb_tag       = 6'($urandom_range(0, 7));
      cdb_data      = $urandom;
      issueint_done = 1'($urandom);
      branch_flush  = 1'($urandom_range(0, 15) == 0);
      branch_commit = 1'($urandom_range(0, 11) == 0);
      @(negedge clk);
      s = model_sel();
      n_tests++;
      if (occupancy !== CNT_W'(mq.size())) begin
        n_fail++;
        $display("FAIL rand_occ cycle %0d: got %0d required %0d", c, occupancy, mq.size());
      end
      n_tests++;
      if (issueint_ready !== (s >= 0)) begin
        n_fail++;
        $display("FAIL rand_ready cycle %0d: got %b required %b", c, issueint_ready, s >= 0);
      end
      n_tests++;
      if (dispatch_ready !== ((mq.size() < DEPTH) || ((s >= 0) && issueint_done))) begin
        n_fail++;
        $display("FAIL rand_dready cycle %0d: got %b size %0d", c, dispatch_ready, mq.size());
      end
      if (s >= 0) begin
        n_tests++;
        if (issueint_opcode !== mq[s].opc || issueint_rdtag !== mq[s].rd ||
            issueint_rsdata !== mq[s].rsd || issueint_rtdata !== mq[s].rtd) begin
          n_fail++;
          $display("FAIL rand_issue cycle %0d: got %h/%h/%h/%h required %h/%h/%h/%h", c,
                   issueint_opcode, issueint_rdtag, issueint_rsdata, issueint_rtdata,
                   mq[s].opc, mq[s].rd, mq[s].rsd, mq[s].rtd);
        end
      end
      step();
    end
  endtask

  initial begin
    idle();
    reset_n = 1'b0;
    #1;
    test_reset();
    test_fill();
    test_out_of_order();
    test_full_issue();
    test_bypass();
    test_spec();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
